// File: rtl/stream_mux.sv
// -----------------------------------------------------------------------------
// stream_mux
//
// N-input, WIDTH-bit stream multiplexer with a registered output stage and
// valid/ready handshakes on every channel. Each output beat is tagged with
// the channel it came from. The source channel is chosen in one of two ways:
//   mode = 0 : software-fixed select through sel (no candidate if sel >= N)
//   mode = 1 : round-robin, first valid channel at or after ptr (mod N)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed-select mode
//   in_data    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   out_data   registered output beat
//   out_chan   source channel of out_data
//   out_valid  output register holds a beat
//   out_ready  downstream accepts the current beat
// -----------------------------------------------------------------------------
module stream_mux #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    // Output register and round-robin pointer
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    // Candidate selection and handshake
    logic             load_s;
    logic             cand_valid_s;
    logic [SELW-1:0]  cand_idx_s;
    logic [SELW-1:0]  rr_idx_s;
    logic             grant_s;
    logic [WIDTH-1:0] chan_data_s [N];

    // Unpack the flat data bus so the chosen channel can be indexed directly
    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign chan_data_s[g] = in_data[g*WIDTH +: WIDTH];
    end

    // The register can take a beat when it is empty or being drained this cycle
    assign load_s = ~out_valid_q | out_ready;

    // Candidate decision: fixed select or first valid channel from ptr onward
    always_comb begin
        cand_valid_s = 1'b0;
        cand_idx_s   = {SELW{1'b0}};
        rr_idx_s     = {SELW{1'b0}};
        if (mode == 1'b0) begin
            if (32'(sel) < 32'(N)) begin
                cand_valid_s = 1'b1;
                cand_idx_s   = sel;
            end else begin
                cand_valid_s = 1'b0;
                cand_idx_s   = {SELW{1'b0}};
            end
        end else begin
            // Walk the offsets from farthest to nearest so that the channel
            // closest to ptr is the last one written and therefore wins.
            for (int k = N - 1; k >= 0; k--) begin
                rr_idx_s     = SELW'((32'(ptr_q) + 32'(k)) % 32'(N));
                cand_idx_s   = in_valid[rr_idx_s] ? rr_idx_s : cand_idx_s;
                cand_valid_s = cand_valid_s | in_valid[rr_idx_s];
            end
        end
    end

    // One-hot ready toward the candidate; forced low while reset is asserted
    always_comb begin
        in_ready = {N{1'b0}};
        if (rst_n && load_s && cand_valid_s) begin
            in_ready[cand_idx_s] = 1'b1;
        end else begin
            in_ready = {N{1'b0}};
        end
    end

    // A grant needs a candidate whose valid is up while the register can load
    assign grant_s = load_s & cand_valid_s & in_valid[cand_idx_s];

    // Next-state of the output register and pointer
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (grant_s) begin
            out_data_d  = chan_data_s[cand_idx_s];
            out_chan_d  = cand_idx_s;
            out_valid_d = 1'b1;
            ptr_d       = SELW'((32'(cand_idx_s) + 32'd1) % 32'(N));
        end else if (out_valid_q && out_ready) begin
            // Drained with nothing to replace it: data and channel tag hold
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= {WIDTH{1'b0}};
            out_chan_q  <= {SELW{1'b0}};
            out_valid_q <= 1'b0;
            ptr_q       <= {SELW{1'b0}};
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule
